// File: rtl/operand_deserializer.sv
// operand_deserializer: collects two serial WIDTH-bit words (A then B) and presents them as a parallel pair under valid/ready
module operand_deserializer #(
    parameter int WIDTH     = 12,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    input  logic             sync,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {RX_A, RX_B, HOLD} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a, sh_b, sh_a_nx, sh_b_nx;
    logic             take, last, realign;

    always_comb begin
        sin_ready = state != HOLD;
        realign   = sync && state != HOLD;
        take      = sin_valid && sin_ready && !sync;
        last      = cnt == CW'(WIDTH - 1);
        sh_a_nx   = MSB_FIRST ? {sh_a[WIDTH-2:0], sin} : {sin, sh_a[WIDTH-1:1]};
        sh_b_nx   = MSB_FIRST ? {sh_b[WIDTH-2:0], sin} : {sin, sh_b[WIDTH-1:1]};
        state_nx  = state;
        if (realign)
            state_nx = RX_A;
        else if (take && last)
            state_nx = state == RX_A ? RX_B : HOLD;
        else if (state == HOLD && out_ready)
            state_nx = RX_A;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_A;
            cnt       <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            A_out     <= '0;
            B_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (realign) begin
                cnt  <= '0;
                sh_a <= '0;
                sh_b <= '0;
            end else if (take) begin
                cnt <= last ? '0 : cnt + CW'(1);
                if (state == RX_A)
                    sh_a <= sh_a_nx;
                else
                    sh_b <= sh_b_nx;
                // B's last bit is still in flight, so publish the shifted value directly
                if (state == RX_B && last) begin
                    A_out     <= sh_a;
                    B_out     <= sh_b_nx;
                    out_valid <= 1'b1;
                end
            end
            if (state == HOLD && out_ready)
                out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_deserializer.sv
// tb_operand_deserializer: two instances (MSB-first and LSB-first) on one bit stream, checked against a frame-level model
module tb_operand_deserializer;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst, sin, sin_valid, sync, out_ready;
    logic r_m, v_m, r_l, v_l;
    logic [W-1:0] a_m, b_m, a_l, b_l;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    operand_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(r_m), .sync(sync),
        .A_out(a_m), .B_out(b_m), .out_valid(v_m), .out_ready(out_ready)
    );

    operand_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(r_l), .sync(sync),
        .A_out(a_l), .B_out(b_l), .out_valid(v_l), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: bits collected per frame, words assembled once 2*W have arrived
    bit q[$];
    bit pend = 1'b0;
    logic [W-1:0] ea_m = '0, eb_m = '0, ea_l = '0, eb_l = '0;

    function automatic logic [W-1:0] word(input int off, input bit lsb);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++)
            if (lsb) w[i] = q[off+i];
            else w[W-1-i] = q[off+i];
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            pend = 1'b0;
            ea_m = '0; eb_m = '0; ea_l = '0; eb_l = '0;
        end else if (pend) begin
            if (out_ready) pend = 1'b0;
        end else if (sync) begin
            q.delete();
        end else if (sin_valid) begin
            q.push_back(sin);
            if (q.size() == 2 * W) begin
                ea_m = word(0, 1'b0); eb_m = word(W, 1'b0);
                ea_l = word(0, 1'b1); eb_l = word(W, 1'b1);
                pend = 1'b1;
                q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("msb_sin_ready", r_m, !pend);
            chk("msb_out_valid", v_m, pend);
            chk("msb_A_out", a_m, ea_m);
            chk("msb_B_out", b_m, eb_m);
            chk("lsb_sin_ready", r_l, !pend);
            chk("lsb_out_valid", v_l, pend);
            chk("lsb_A_out", a_l, ea_l);
            chk("lsb_B_out", b_l, eb_l);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n, input bit lsb_first, input bit gap);
        for (int i = 0; i < n; i++) begin
            sin       = lsb_first ? w[i] : w[W-1-i];
            sin_valid = 1'b1;
            tick();
            if (gap) begin
                sin_valid = 1'b0;
                tick();
            end
        end
        sin_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit lsb_first, input bit gap);
        send_bits(a, W, lsb_first, gap);
        send_bits(b, W, lsb_first, gap);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_valid", v_m, 1'b0);
        chk("reset_A", a_m, 12'h000);
        chk("reset_ready", r_m, 1'b1);

        // basic frame
        send_frame(12'ha4b, 12'h101, 1'b0, 1'b0);
        chk("t1_valid", v_m, 1'b1);
        chk("t1_A", a_m, 12'ha4b);
        chk("t1_B", b_m, 12'h101);

        // backpressure, with sync in HOLD ignored on the last cycle
        sin = 1'b1; sin_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sync = (i == 4);
            tick();
            chk("t2_ready", r_m, 1'b0);
            chk("t2_valid", v_m, 1'b1);
            chk("t2_A", a_m, 12'ha4b);
            chk("t2_B", b_m, 12'h101);
        end
        sync = 1'b0; sin_valid = 1'b0;
        handshake();
        chk("t2_drop", v_m, 1'b0);
        chk("t2_ready_back", r_m, 1'b1);
        chk("t2_A_kept", a_m, 12'ha4b);

        // gapped input
        send_frame(12'hfff, 12'h000, 1'b0, 1'b1);
        chk("t3_valid", v_m, 1'b1);
        chk("t3_A", a_m, 12'hfff);
        chk("t3_B", b_m, 12'h000);
        handshake();

        // sync realign after garbage
        send_bits(12'h5a5, 7, 1'b0, 1'b0);
        sync = 1'b1; sin_valid = 1'b1; sin = 1'b1;
        tick();
        sync = 1'b0; sin_valid = 1'b0;
        send_bits(12'h123, W, 1'b0, 1'b0);
        send_bits(12'h456, W - 1, 1'b0, 1'b0);
        chk("t4_early", v_m, 1'b0);
        send_bits(12'h456 << (W - 1), 1, 1'b0, 1'b0);
        chk("t4_valid", v_m, 1'b1);
        chk("t4_A", a_m, 12'h123);
        chk("t4_B", b_m, 12'h456);
        handshake();

        // reset mid-frame
        send_bits(12'h9c7, W, 1'b0, 1'b0);
        send_bits(12'h3e1, 5, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_A", a_m, 12'h000);
        chk("t5_B", b_m, 12'h000);
        chk("t5_valid", v_m, 1'b0);
        send_frame(12'h5a5, 12'h3c3, 1'b0, 1'b0);
        chk("t5_fresh_A", a_m, 12'h5a5);
        chk("t5_fresh_B", b_m, 12'h3c3);
        handshake();

        // LSB-first stream into the LSB-first instance
        send_frame(12'ha4b, 12'h101, 1'b1, 1'b0);
        chk("t6_valid", v_l, 1'b1);
        chk("t6_A", a_l, 12'ha4b);
        chk("t6_B", b_l, 12'h101);
        handshake();
        tick();
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
